// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: walks a 16-bit register list and issues one memory transfer per set bit.
// Define LSM_ABORT_EN to add the mem_abort input and aborted output (early sequence termination).
module lsm_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_load,
    input  logic [15:0]      reg_list,
    input  logic [WIDTH-1:0] base,
    input  logic             up,
    input  logic             pre,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [3:0]       ra,
    input  logic [WIDTH-1:0] rd,
    output logic             rf_we,
    output logic [3:0]       rf_wa,
    output logic [WIDTH-1:0] rf_wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] wb_addr
`ifdef LSM_ABORT_EN
    ,
    input  logic             mem_abort,
    output logic             aborted
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] ADDR_STEP = WIDTH'(4);

    state_t           r_state;
    logic [15:0]      r_mask;
    logic             r_isLoad;
    logic             r_memReq;
    logic             r_memWe;
    logic [WIDTH-1:0] r_addr;
    logic [3:0]       r_ra;
    logic             r_rfWe;
    logic [3:0]       r_rfWa;
    logic [WIDTH-1:0] r_rfWd;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_wbAddr;
    logic [WIDTH-1:0] r_wbFinal;
`ifdef LSM_ABORT_EN
    logic [WIDTH-1:0] r_base;
    logic             r_aborted;
`endif

    logic [4:0]       w_count;
    logic [WIDTH-1:0] w_span;
    logic [WIDTH-1:0] w_firstAddr;
    logic [WIDTH-1:0] w_wbStart;
    logic [15:0]      w_nextMask;
    logic [3:0]       w_nextIdx;
    logic             w_accept;
    logic             w_abort;

    function automatic logic [3:0] f_lowIdx(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    always_comb begin
        w_count = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_count = w_count + {4'd0, reg_list[i]};
        end
    end

    // Transfers always climb in address; only the lowest address depends on up/pre.
    assign w_span = WIDTH'({w_count, 2'b00});

    always_comb begin
        case ({up, pre})
            2'b10:   w_firstAddr = base;
            2'b11:   w_firstAddr = base + ADDR_STEP;
            2'b00:   w_firstAddr = base - w_span + ADDR_STEP;
            default: w_firstAddr = base - w_span;
        endcase
    end

    assign w_wbStart  = up ? (base + w_span) : (base - w_span);
    assign w_nextMask = r_mask & ~(16'd1 << r_ra);
    assign w_nextIdx  = f_lowIdx(w_nextMask);
    assign w_accept   = r_memReq & mem_ready;
`ifdef LSM_ABORT_EN
    assign w_abort    = r_memReq & mem_abort;
`else
    assign w_abort    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            r_isLoad  <= 1'b0;
            r_memReq  <= 1'b0;
            r_memWe   <= 1'b0;
            r_addr    <= '0;
            r_ra      <= '0;
            r_rfWe    <= 1'b0;
            r_rfWa    <= '0;
            r_rfWd    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wbAddr  <= '0;
            r_wbFinal <= '0;
`ifdef LSM_ABORT_EN
            r_base    <= '0;
            r_aborted <= 1'b0;
`endif
        end else begin
            r_rfWe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mask    <= reg_list;
                        r_isLoad  <= is_load;
                        r_addr    <= w_firstAddr;
                        r_ra      <= f_lowIdx(reg_list);
                        r_wbFinal <= w_wbStart;
                        r_busy    <= 1'b1;
                        r_memWe   <= ~is_load & (|reg_list);
`ifdef LSM_ABORT_EN
                        r_base    <= base;
`endif
                        if (reg_list == 16'd0) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_wbAddr <= w_wbStart;
                        end else begin
                            r_state  <= S_XFER;
                            r_memReq <= 1'b1;
                        end
                    end
                end
                S_XFER: begin
`ifdef LSM_ABORT_EN
                    if (w_abort) begin
                        r_state   <= S_DONE;
                        r_memReq  <= 1'b0;
                        r_memWe   <= 1'b0;
                        r_done    <= 1'b1;
                        r_wbAddr  <= r_base;
                        r_aborted <= 1'b1;
                    end else
`endif
                    if (w_accept) begin
                        r_mask <= w_nextMask;
                        if (r_isLoad) begin
                            r_rfWe <= 1'b1;
                            r_rfWa <= r_ra;
                            r_rfWd <= mem_rdata;
                        end
                        if (w_nextMask == 16'd0) begin
                            r_state  <= S_DONE;
                            r_memReq <= 1'b0;
                            r_memWe  <= 1'b0;
                            r_done   <= 1'b1;
                            r_wbAddr <= r_wbFinal;
                        end else begin
                            r_addr <= r_addr + ADDR_STEP;
                            r_ra   <= w_nextIdx;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
`ifdef LSM_ABORT_EN
                    r_aborted <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Store data comes straight from the register file so it tracks ra without a pipeline bubble.
    assign mem_wdata = (r_memReq && r_memWe) ? rd : '0;
    assign mem_req   = r_memReq;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_addr;
    assign ra        = r_ra;
    assign rf_we     = r_rfWe;
    assign rf_wa     = r_rfWa;
    assign rf_wd     = r_rfWd;
    assign busy      = r_busy;
    assign done      = r_done;
    assign wb_addr   = r_wbAddr;
`ifdef LSM_ABORT_EN
    assign aborted   = r_aborted;
`endif

endmodule

// File: tb/tb_lsm_sequencer.sv
// Testbench for lsm_sequencer: directed scenarios plus randomized sequences against a list-based reference model.
// Define LSM_ABORT_EN to also exercise the abort path.
module tb_lsm_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         isLoad = 1'b0;
    logic [15:0]  regList = '0;
    logic [W-1:0] base = '0;
    logic         up = 1'b0;
    logic         pre = 1'b0;
    logic         memReq, memWe, rfWe, busy, done;
    logic [W-1:0] memAddr, memWdata, rfWd, wbAddr, rd, memRdata;
    logic         memReady = 1'b0;
    logic [3:0]   ra, rfWa;
`ifdef LSM_ABORT_EN
    logic         memAbort = 1'b0;
    logic         aborted;
    logic         doneAborted;
    int           abortAt = 0;
`endif

    logic [W-1:0] regVals [16];
    logic [W-1:0] rdataSalt = '0;
    int           readyPct = 100;
    int           stallLeft = 0;
    int           checks = 0;
    int           errors = 0;

    int cycle = 0, startCount, startCycle, firstReqCycle, reqCount, busyCount;
    int doneCount, doneCycle, stableErrs, accepted;
    logic [W-1:0] doneWb;
    logic         prevPending, prevWe, abortNow;
    logic [W-1:0] prevAddr, prevWdata;
    logic [W-1:0] accAddr[$], accWdata[$], rfWdQ[$];
    logic         accWe[$];
    logic [3:0]   accRa[$], rfWaQ[$];
    int           accCycle[$], rfCycle[$];

    logic [3:0]   expIdx[$];
    logic [W-1:0] expAddr[$];
    logic [W-1:0] expWb;

    always #5 clk = ~clk;

    assign rd       = regVals[ra];
    assign memRdata = memAddr ^ rdataSalt;

    lsm_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_load(isLoad), .reg_list(regList),
        .base(base), .up(up), .pre(pre), .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr),
        .mem_wdata(memWdata), .mem_ready(memReady), .mem_rdata(memRdata), .ra(ra), .rd(rd),
        .rf_we(rfWe), .rf_wa(rfWa), .rf_wd(rfWd), .busy(busy), .done(done), .wb_addr(wbAddr)
`ifdef LSM_ABORT_EN
        , .mem_abort(memAbort), .aborted(aborted)
`endif
    );

    // Memory-side driver: stall count first, then random readiness; inputs change 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stallLeft > 0 && memReq) begin
                memReady = 1'b0;
                stallLeft--;
            end else begin
                memReady = ($urandom_range(99) < readyPct);
            end
`ifdef LSM_ABORT_EN
            memAbort = (abortAt > 0) && memReq && (accepted == abortAt - 1);
`endif
        end
    end

    // Observer: records every transaction at the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
`ifdef LSM_ABORT_EN
            abortNow = memAbort;
`else
            abortNow = 1'b0;
`endif
            if (reset_n) begin
                if (start && !busy) begin
                    startCount++;
                    startCycle = cycle;
                end
                if (memReq) begin
                    reqCount++;
                    if (firstReqCycle < 0) firstReqCycle = cycle;
                end
                if (prevPending && !(memReq && memAddr === prevAddr && memWdata === prevWdata && memWe === prevWe))
                    stableErrs++;
                prevPending = memReq && !memReady && !abortNow;
                prevAddr = memAddr;
                prevWdata = memWdata;
                prevWe = memWe;
                if (memReq && memReady && !abortNow) begin
                    accAddr.push_back(memAddr);
                    accWdata.push_back(memWdata);
                    accWe.push_back(memWe);
                    accRa.push_back(ra);
                    accCycle.push_back(cycle);
                    accepted++;
                end
                if (rfWe) begin
                    rfWaQ.push_back(rfWa);
                    rfWdQ.push_back(rfWd);
                    rfCycle.push_back(cycle);
                end
                if (busy) busyCount++;
                if (done) begin
                    doneCount++;
                    doneCycle = cycle;
                    doneWb = wbAddr;
`ifdef LSM_ABORT_EN
                    doneAborted = aborted;
`endif
                end
            end else begin
                prevPending = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] simulation did not terminate");
    end

    task automatic clear_records();
        startCount = 0; startCycle = -1; firstReqCycle = -1; reqCount = 0; busyCount = 0;
        doneCount = 0; doneCycle = -1; stableErrs = 0; accepted = 0; doneWb = '0; prevPending = 1'b0;
        accAddr.delete(); accWdata.delete(); accWe.delete(); accRa.delete(); accCycle.delete();
        rfWaQ.delete(); rfWdQ.delete(); rfCycle.delete();
    endtask

    // Reference model: selected registers in ascending order, ascending addresses from the lowest one.
    function automatic void build_model(input logic [15:0] list, input logic [W-1:0] b, input logic u, input logic p);
        logic [W-1:0] lowest;
        int n;
        expIdx.delete();
        expAddr.delete();
        for (int i = 0; i < 16; i++) if (list[i]) expIdx.push_back(4'(i));
        n = expIdx.size();
        if (u) lowest = p ? b + 32'd4 : b;
        else   lowest = p ? b - W'(4 * n) : b - W'(4 * n) + 32'd4;
        for (int k = 0; k < n; k++) expAddr.push_back(lowest + W'(4 * k));
        expWb = u ? b + W'(4 * n) : b - W'(4 * n);
    endfunction

    task automatic drive_start(input logic ld, input logic [15:0] list, input logic [W-1:0] b, input logic u, input logic p);
        @(posedge clk);
        #1;
        start = 1'b1; isLoad = ld; regList = list; base = b; up = u; pre = p;
        @(posedge clk);
        #1;
        start = 1'b0;
        isLoad = 1'($urandom); regList = 16'($urandom); base = $urandom; up = 1'($urandom); pre = 1'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (doneCount > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, memReq, memWe, rfWe} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl: got %b, want 00000", {busy, done, memReq, memWe, rfWe});
        end
        checks++;
        if ({memAddr, memWdata} !== '0) begin
            errors++; $display("[TB] FAIL reset_mem: got %h/%h, want 0", memAddr, memWdata);
        end
        checks++;
        if ({ra, rfWa, rfWd, wbAddr} !== '0) begin
            errors++; $display("[TB] FAIL reset_rf: got ra=%h wa=%h wd=%h wb=%h, want 0", ra, rfWa, rfWd, wbAddr);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_idle_busy: got %b, want 0", busy);
        end
    endtask

    task automatic test_store_basic();
        logic [W-1:0] wantAddr [3];
        bit ok;
        wantAddr[0] = 32'h100; wantAddr[1] = 32'h104; wantAddr[2] = 32'h108;
        readyPct = 100;
        for (int i = 0; i < 16; i++) regVals[i] = $urandom;
        clear_records();
        drive_start(1'b0, 16'h0007, 32'h100, 1'b1, 1'b0);
        wait_done(100, ok);
        checks++;
        if (!ok || accAddr.size() != 3) begin
            errors++; $display("[TB] FAIL store_count: got %0d (done=%0b), want 3", accAddr.size(), ok);
        end
        for (int k = 0; k < 3 && k < accAddr.size(); k++) begin
            checks++;
            if (accAddr[k] !== wantAddr[k] || accRa[k] !== 4'(k) || accWe[k] !== 1'b1 ||
                accWdata[k] !== regVals[k] || accCycle[k] != startCycle + 1 + k) begin
                errors++;
                $display("[TB] FAIL store_xfer[%0d]: got addr=%h ra=%h we=%b wd=%h cyc=%0d, want addr=%h ra=%h we=1 wd=%h cyc=%0d",
                         k, accAddr[k], accRa[k], accWe[k], accWdata[k], accCycle[k], wantAddr[k], k, regVals[k], startCycle + 1 + k);
            end
        end
        checks++;
        if (doneWb !== 32'h10C || doneCycle != startCycle + 4 || doneCount != 1) begin
            errors++; $display("[TB] FAIL store_done: got wb=%h cyc=%0d cnt=%0d, want wb=10c cyc=%0d cnt=1", doneWb, doneCycle, doneCount, startCycle + 4);
        end
        checks++;
        if (rfWaQ.size() != 0 || busyCount != 4) begin
            errors++; $display("[TB] FAIL store_rf_busy: got rfwe=%0d busy=%0d, want 0/4", rfWaQ.size(), busyCount);
        end
    endtask

    task automatic test_load_basic();
        logic [W-1:0] wantAddr [3];
        logic [W-1:0] wantWd [3];
        logic [3:0]   wantIdx [3];
        bit ok;
        wantAddr[0] = 32'h1F4; wantAddr[1] = 32'h1F8; wantAddr[2] = 32'h1FC;
        wantWd[0] = 32'h10B; wantWd[1] = 32'h107; wantWd[2] = 32'h103;
        wantIdx[0] = 4'd0; wantIdx[1] = 4'd4; wantIdx[2] = 4'd15;
        readyPct = 100;
        rdataSalt = 32'hFF;
        clear_records();
        drive_start(1'b1, 16'h8011, 32'h200, 1'b0, 1'b1);
        wait_done(100, ok);
        checks++;
        if (!ok || accAddr.size() != 3 || rfWaQ.size() != 3) begin
            errors++; $display("[TB] FAIL load_count: got acc=%0d rf=%0d, want 3/3", accAddr.size(), rfWaQ.size());
        end
        for (int k = 0; k < 3 && k < accAddr.size() && k < rfWaQ.size(); k++) begin
            checks++;
            if (accAddr[k] !== wantAddr[k] || accWe[k] !== 1'b0 || rfWaQ[k] !== wantIdx[k] ||
                rfWdQ[k] !== wantWd[k] || rfCycle[k] != accCycle[k] + 1) begin
                errors++;
                $display("[TB] FAIL load_xfer[%0d]: got addr=%h we=%b wa=%h wd=%h, want addr=%h we=0 wa=%h wd=%h",
                         k, accAddr[k], accWe[k], rfWaQ[k], rfWdQ[k], wantAddr[k], wantIdx[k], wantWd[k]);
            end
        end
        checks++;
        if (doneWb !== 32'h1F4 || doneCycle != startCycle + 4) begin
            errors++; $display("[TB] FAIL load_done: got wb=%h cyc=%0d, want wb=1f4 cyc=%0d", doneWb, doneCycle, startCycle + 4);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] b;
        bit ok;
        b = $urandom & 32'hFFFF_FFFC;
        readyPct = 100;
        stallLeft = 3;
        clear_records();
        drive_start(1'b0, 16'h0003, b, 1'b1, 1'b0);
        wait_done(100, ok);
        checks++;
        if (!ok || accAddr.size() != 2) begin
            errors++; $display("[TB] FAIL stall_count: got %0d, want 2", accAddr.size());
        end else begin
            checks++;
            if (accAddr[0] !== b || accAddr[1] !== b + 32'd4 || accCycle[0] != startCycle + 4 || accCycle[1] != accCycle[0] + 1) begin
                errors++; $display("[TB] FAIL stall_timing: got %h@%0d %h@%0d, want %h@%0d %h@%0d",
                                   accAddr[0], accCycle[0], accAddr[1], accCycle[1], b, startCycle + 4, b + 32'd4, startCycle + 5);
            end
        end
        checks++;
        if (stableErrs != 0 || reqCount != 5) begin
            errors++; $display("[TB] FAIL stall_hold: got unstable=%0d req=%0d, want 0/5", stableErrs, reqCount);
        end
    endtask

    task automatic test_empty();
        logic [W-1:0] b;
        bit ok;
        b = $urandom;
        clear_records();
        drive_start(1'($urandom), 16'h0000, b, 1'($urandom), 1'($urandom));
        wait_done(20, ok);
        checks++;
        if (!ok || reqCount != 0 || doneCycle != startCycle + 1 || doneWb !== b || busyCount != 1 || doneCount != 1) begin
            errors++; $display("[TB] FAIL empty: got req=%0d dcyc=%0d wb=%h busy=%0d, want 0/%0d/%h/1",
                               reqCount, doneCycle, doneWb, busyCount, startCycle + 1, b);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] b;
        logic [15:0]  list;
        bit ok;
        b = $urandom;
        readyPct = 100;
        clear_records();
        drive_start(1'b0, 16'h000F, b, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (memReq !== 1'b1 || memAddr !== b + 32'd4) begin
            errors++; $display("[TB] FAIL rstmid_second: got req=%b addr=%h, want 1/%h", memReq, memAddr, b + 32'd4);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, memReq, memWe, rfWe} !== 5'b0 || {memAddr, memWdata, ra, rfWa, rfWd, wbAddr} !== '0) begin
            errors++; $display("[TB] FAIL rstmid_zero: got ctrl=%b addr=%h ra=%h wb=%h, want 0",
                               {busy, done, memReq, memWe, rfWe}, memAddr, ra, wbAddr);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        list = 16'($urandom) | 16'h0100;
        b = $urandom;
        build_model(list, b, 1'b1, 1'b1);
        clear_records();
        drive_start(1'b0, list, b, 1'b1, 1'b1);
        wait_done(200, ok);
        checks++;
        if (!ok || accAddr.size() != expAddr.size() || doneWb !== expWb) begin
            errors++; $display("[TB] FAIL rstmid_restart: got acc=%0d wb=%h, want %0d/%h", accAddr.size(), doneWb, expAddr.size(), expWb);
        end
    endtask

    task automatic test_busy_start();
        logic [15:0]  list;
        logic [W-1:0] b;
        logic         u, p;
        bit ok;
        list = 16'($urandom) | 16'h0021;
        b = $urandom; u = 1'($urandom); p = 1'($urandom);
        readyPct = 40;
        for (int i = 0; i < 16; i++) regVals[i] = $urandom;
        build_model(list, b, u, p);
        clear_records();
        drive_start(1'b0, list, b, u, p);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                start = 1'($urandom); isLoad = 1'($urandom); regList = 16'($urandom); base = $urandom;
            end else begin
                start = 1'b0;
            end
            if (doneCount > 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        repeat (4) @(posedge clk);
        checks++;
        if (!ok || doneCount != 1 || startCount != 1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL busy_start_ignore: got done=%0d starts=%0d busy=%b, want 1/1/0", doneCount, startCount, busy);
        end
        checks++;
        if (accAddr.size() != expAddr.size() || doneWb !== expWb || stableErrs != 0) begin
            errors++; $display("[TB] FAIL busy_start_seq: got acc=%0d wb=%h unstable=%0d, want %0d/%h/0",
                               accAddr.size(), doneWb, stableErrs, expAddr.size(), expWb);
        end
        for (int k = 0; k < expAddr.size() && k < accAddr.size(); k++) begin
            checks++;
            if (accAddr[k] !== expAddr[k] || accRa[k] !== expIdx[k] || accWdata[k] !== regVals[expIdx[k]]) begin
                errors++; $display("[TB] FAIL busy_start_xfer[%0d]: got %h/%h/%h, want %h/%h/%h",
                                   k, accAddr[k], accRa[k], accWdata[k], expAddr[k], expIdx[k], regVals[expIdx[k]]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0]  list;
        logic [W-1:0] b;
        logic         ld, u, p;
        int           n;
        bit ok;
        for (int it = 0; it < 30; it++) begin
            ld = 1'($urandom); u = 1'($urandom); p = 1'($urandom); b = $urandom;
            list = ($urandom_range(7) == 0) ? 16'h0000 : 16'($urandom);
            readyPct = 30 + $urandom_range(70);
            rdataSalt = $urandom;
            for (int i = 0; i < 16; i++) regVals[i] = $urandom;
            build_model(list, b, u, p);
            n = expAddr.size();
            clear_records();
            drive_start(ld, list, b, u, p);
            wait_done(2000, ok);
            checks++;
            if (!ok || accAddr.size() != n || rfWaQ.size() != (ld ? n : 0) || doneWb !== expWb) begin
                errors++; $display("[TB] FAIL rand[%0d]_summary: got acc=%0d rf=%0d wb=%h, want %0d/%0d/%h",
                                   it, accAddr.size(), rfWaQ.size(), doneWb, n, ld ? n : 0, expWb);
            end
            checks++;
            if (reqCount != doneCycle - startCycle - 1 || busyCount != doneCycle - startCycle || stableErrs != 0 ||
                (n > 0 && firstReqCycle != startCycle + 1)) begin
                errors++; $display("[TB] FAIL rand[%0d]_timing: got req=%0d busy=%0d unstable=%0d first=%0d, want %0d/%0d/0/%0d",
                                   it, reqCount, busyCount, stableErrs, firstReqCycle, doneCycle - startCycle - 1,
                                   doneCycle - startCycle, startCycle + 1);
            end
            for (int k = 0; k < n && k < accAddr.size(); k++) begin
                checks++;
                if (accAddr[k] !== expAddr[k] || accRa[k] !== expIdx[k] || accWe[k] !== !ld ||
                    (!ld && accWdata[k] !== regVals[expIdx[k]])) begin
                    errors++; $display("[TB] FAIL rand[%0d]_xfer[%0d]: got %h/%h/%b, want %h/%h/%b",
                                       it, k, accAddr[k], accRa[k], accWe[k], expAddr[k], expIdx[k], !ld);
                end
            end
            for (int k = 0; ld && k < n && k < rfWaQ.size(); k++) begin
                checks++;
                if (rfWaQ[k] !== expIdx[k] || rfWdQ[k] !== (expAddr[k] ^ rdataSalt)) begin
                    errors++; $display("[TB] FAIL rand[%0d]_rf[%0d]: got %h/%h, want %h/%h",
                                       it, k, rfWaQ[k], rfWdQ[k], expIdx[k], expAddr[k] ^ rdataSalt);
                end
            end
        end
    endtask

`ifdef LSM_ABORT_EN
    task automatic test_abort();
        logic [W-1:0] b;
        bit ok;
        b = $urandom;
        readyPct = 100;
        abortAt = 2;
        clear_records();
        drive_start(1'b1, 16'h00F0, b, 1'b1, 1'b0);
        wait_done(100, ok);
        abortAt = 0;
        checks++;
        if (!ok || doneAborted !== 1'b1 || accepted != 1 || rfWaQ.size() != 1 || doneWb !== b || reqCount != 2) begin
            errors++; $display("[TB] FAIL abort: got ab=%b acc=%0d rf=%0d wb=%h req=%0d, want 1/1/1/%h/2",
                               doneAborted, accepted, rfWaQ.size(), doneWb, reqCount, b);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) regVals[i] = $urandom;
        clear_records();
        test_reset();
        test_store_basic();
        test_load_basic();
        test_stall();
        test_empty();
        test_reset_mid();
        test_busy_start();
        test_random();
`ifdef LSM_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
